// File: rtl/carrier_update_ctrl_if.sv
// Config write channel for the carrier update controller.
// Valid/ready handshake carrying channel select and new period/init.
interface carrier_update_ctrl_if #(
   parameter int NCH = 4,
   parameter int CW  = 16
) ();
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   logic           cfg_valid;
   logic           cfg_ready;
   logic [CHW-1:0] cfg_ch;
   logic [CW-1:0]  cfg_period;
   logic [CW-1:0]  cfg_init;

   modport master (
      output cfg_valid, cfg_ch, cfg_period, cfg_init,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_period, cfg_init,
      output cfg_ready
   );
endinterface

// File: rtl/carrier_update_ctrl.sv
// Staggered start, shadowed period/init updates committed on mask events,
// and a bounded drain before stopping the carrier channels.
module carrier_update_ctrl #(
   parameter int NCH       = 4,
   parameter int CW        = 16,
   parameter int DRAIN_TMO = 1024
) (
   input  logic                clk,
   input  logic                reset,
   carrier_update_ctrl_if.slave cfg,
   input  logic                cmd_start,
   input  logic                cmd_stop,
   input  logic [NCH-1:0]      mask_event,
   output logic [NCH*CW-1:0]   period,
   output logic [NCH*CW-1:0]   init_carr,
   output logic [NCH-1:0]      pwm_on,
   output logic [NCH-1:0]      pending,
   output logic [NCH-1:0]      update_done,
   output logic [1:0]          state
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int DW  = (DRAIN_TMO > 1) ? $clog2(DRAIN_TMO) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARM   = 2'd1,
      S_RUN   = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t            state_q, state_n;
   logic [CHW-1:0]    idx_q, idx_n;
   logic [DW-1:0]     dcnt_q, dcnt_n;
   logic [NCH*CW-1:0] shp_q, shp_n;
   logic [NCH*CW-1:0] shi_q, shi_n;
   logic [NCH*CW-1:0] per_n, ini_n;
   logic [NCH-1:0]    pwm_n, pend_n, done_n;
   logic [NCH-1:0]    ch_hit, wr;
   logic              rdy, xfer, drain_exit;

   always_comb begin
      ch_hit = '0;
      for (int k = 0; k < NCH; k++)
         ch_hit[k] = (cfg.cfg_ch == CHW'(k));
   end

   // A channel with an uncommitted shadow blocks further writes to it.
   always_comb begin
      unique case (state_q)
         S_IDLE:  rdy = 1'b1;
         S_RUN:   rdy = ~|(pending & ch_hit);
         default: rdy = 1'b0;
      endcase
   end

   assign cfg.cfg_ready = rdy;
   assign xfer          = cfg.cfg_valid & rdy;
   assign wr            = ch_hit & {NCH{xfer}};
   assign state         = state_q;

   always_comb begin
      state_n    = state_q;
      idx_n      = idx_q;
      dcnt_n     = dcnt_q;
      shp_n      = shp_q;
      shi_n      = shi_q;
      per_n      = period;
      ini_n      = init_carr;
      pwm_n      = pwm_on;
      pend_n     = pending;
      done_n     = '0;
      drain_exit = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            for (int k = 0; k < NCH; k++) begin
               if (wr[k]) begin
                  per_n[k*CW +: CW] = cfg.cfg_period;
                  ini_n[k*CW +: CW] = cfg.cfg_init;
               end
            end
            if (cmd_start && !cmd_stop) begin
               state_n = S_ARM;
               idx_n   = '0;
            end
         end
         S_ARM: begin
            if (cmd_stop) begin
               pwm_n   = '0;
               idx_n   = '0;
               state_n = S_IDLE;
            end else begin
               pwm_n[idx_q] = 1'b1;
               idx_n        = idx_q + CHW'(1);
               if (idx_q == CHW'(NCH-1)) begin
                  idx_n   = '0;
                  state_n = S_RUN;
               end
            end
         end
         S_RUN: begin
            for (int k = 0; k < NCH; k++) begin
               if (mask_event[k] && pending[k]) begin
                  per_n[k*CW +: CW] = shp_q[k*CW +: CW];
                  ini_n[k*CW +: CW] = shi_q[k*CW +: CW];
                  pend_n[k]         = 1'b0;
                  done_n[k]         = 1'b1;
               end else if (wr[k]) begin
                  shp_n[k*CW +: CW] = cfg.cfg_period;
                  shi_n[k*CW +: CW] = cfg.cfg_init;
                  pend_n[k]         = 1'b1;
               end
            end
            if (cmd_stop) begin
               state_n = S_DRAIN;
               dcnt_n  = '0;
            end
         end
         S_DRAIN: begin
            drain_exit = mask_event[0] ||
                         (dcnt_q == DW'(DRAIN_TMO-1));
            for (int k = 0; k < NCH; k++) begin
               if (pending[k] && (mask_event[k] || drain_exit)) begin
                  per_n[k*CW +: CW] = shp_q[k*CW +: CW];
                  ini_n[k*CW +: CW] = shi_q[k*CW +: CW];
                  pend_n[k]         = 1'b0;
                  done_n[k]         = 1'b1;
               end
            end
            dcnt_n = dcnt_q + DW'(1);
            if (drain_exit) begin
               pwm_n   = '0;
               dcnt_n  = '0;
               state_n = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         dcnt_q      <= '0;
         shp_q       <= '0;
         shi_q       <= '0;
         period      <= '0;
         init_carr   <= '0;
         pwm_on      <= '0;
         pending     <= '0;
         update_done <= '0;
      end else begin
         state_q     <= state_n;
         idx_q       <= idx_n;
         dcnt_q      <= dcnt_n;
         shp_q       <= shp_n;
         shi_q       <= shi_n;
         period      <= per_n;
         init_carr   <= ini_n;
         pwm_on      <= pwm_n;
         pending     <= pend_n;
         update_done <= done_n;
      end
   end
endmodule

// File: doc/carrier_update_ctrl.md
CARRIER_UPDATE_CTRL -- requirements
Module: carrier_update_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 4: number of carrier channels controlled (2..8).
REQ-002 SHALL have parameter CW, default 16: carrier count width, equal to `PWMCOUNT_WIDTH.
REQ-003 SHALL have parameter DRAIN_TMO, default 1024: maximum DRAIN dwell in clk cycles.
REQ-004 SHALL have port clk  in  1  single system clock; all logic on posedge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port cfg_valid  in  1  config write request.
REQ-007 SHALL have port cfg_ready  out  1  config write accept; a transfer occurs when cfg_valid and cfg_ready are both high.
REQ-008 SHALL have port cfg_ch  in  clog2(NCH)  target channel.
REQ-009 SHALL have port cfg_period  in  CW  new period.
REQ-010 SHALL have port cfg_init  in  CW  new initial carrier value.
REQ-011 SHALL have port cmd_start  in  1  single-cycle start pulse.
REQ-012 SHALL have port cmd_stop  in  1  single-cycle stop pulse.
REQ-013 SHALL have port mask_event  in  NCH  per-channel mask_event from the carrier generators.
REQ-014 SHALL have port period  out  NCH*CW  active period per channel; channel k at bits [k*CW +: CW].
REQ-015 SHALL have port init_carr  out  NCH*CW  active init value per channel, packed the same way as period.
REQ-016 SHALL have port pwm_on  out  NCH  per-channel enable; 1 = PWM_ON.
REQ-017 SHALL have port pending  out  NCH  shadow register holds an uncommitted write.
REQ-018 SHALL have port update_done  out  NCH  one-cycle pulse when a shadow commits to active.
REQ-019 SHALL have port state  out  2  FSM state: IDLE=0, ARM=1, RUN=2, DRAIN=3.

Function
REQ-020 SHALL be one FSM with states IDLE, ARM, RUN and DRAIN; all outputs SHALL be registered, except cfg_ready, which SHALL be combinational from state, pending and cfg_ch.
REQ-021 SHALL, in IDLE, drive cfg_ready=1, write accepted data directly to active period/init_carr on the next edge, and leave pending unchanged at 0.
REQ-022 SHALL, in IDLE on cmd_start with cmd_stop low, enter ARM with an arm index of 0; start and stop together in IDLE SHALL keep the block in IDLE.
REQ-023 SHALL, in ARM, set pwm_on[idx] and increment idx each cycle, so channel k is enabled k cycles after channel 0; after pwm_on[NCH-1] is set, the block SHALL enter RUN.
REQ-024 SHALL, in ARM and DRAIN, drive cfg_ready=0.
REQ-025 SHALL, in ARM on cmd_stop, clear all pwm_on on the next edge and enter IDLE.
REQ-026 SHALL, in RUN, drive cfg_ready = !pending[cfg_ch]; an accepted write SHALL load that channel's shadow registers and set its pending bit.
REQ-027 SHALL, in RUN, on mask_event[k] with pending[k]=1, copy the shadow to active, clear pending[k] and pulse update_done[k], all on the same edge.
REQ-028 SHALL ignore mask_event[k] with pending[k]=0.
REQ-029 SHALL, because cfg_ready is low while pending[k]=1, never let a write and a commit to the same channel coincide; writes to other channels SHALL proceed independently in the same cycle.
REQ-030 SHALL, in RUN on cmd_stop, enter DRAIN and clear the drain counter; cmd_start in RUN SHALL be ignored.
REQ-031 SHALL, in DRAIN, keep pwm_on unchanged, continue per-channel commits, and increment the drain counter each cycle.
REQ-032 SHALL exit DRAIN on mask_event[0] or when the drain counter reaches DRAIN_TMO-1, whichever comes first.
REQ-033 SHALL, on DRAIN exit, clear all pwm_on, commit every pending shadow to active (pulsing the matching update_done bits), clear pending, and enter IDLE.
REQ-034 SHALL ignore cmd_start and cmd_stop in DRAIN.
REQ-035 SHALL compare the drain counter at full width with no wrap; width is clog2(DRAIN_TMO).
REQ-036 SHALL copy period and init values bit-exact with no arithmetic; range checks are the carrier generator's job.

Reset
REQ-037 SHALL, on reset high at a clk edge, set state=IDLE and clear pwm_on, pending, update_done, all active and shadow registers, the arm index and the drain counter, from any state including mid-ARM and mid-DRAIN.
REQ-038 SHALL give reset priority over every other input in the same cycle.

Verification
REQ-039 SHALL verify: in IDLE, write ch1 period=100 init=5 -> period[1]=100 and init_carr[1]=5 one cycle later; pending=0.
REQ-040 SHALL verify: cmd_start with NCH=4 -> pwm_on goes 0001, 0011, 0111, 1111 on consecutive cycles, then state=RUN.
REQ-041 SHALL verify: in RUN, write ch2 period=200 -> pending[2]=1 and period[2] unchanged; a second ch2 write sees cfg_ready=0; mask_event[2] -> period[2]=200, pending[2]=0, update_done[2] high for one cycle.
REQ-042 SHALL verify: in RUN, cmd_stop with mask_event[0] 10 cycles later -> pwm_on=0 and state=IDLE on cycle 11; a pending ch3 commits on the same edge.
REQ-043 SHALL verify: cmd_stop with no mask_event, DRAIN_TMO=1024 -> IDLE exactly 1024 cycles after entering DRAIN.
REQ-044 SHALL verify: reset asserted in ARM after 2 channels are enabled -> next edge gives pwm_on=0, state=IDLE, and all registers zero.
